ws_psum_accumulator: RTL and testbench

- Sits directly downstream of the bottom ws_processing_element of a weight-stationary PE column.
- Consumes the column's final psum stream (psum_o_data/psum_o_valid) and accumulates it per output position over multiple passes (input channels / kernel rows) in a local buffer.
- After the last pass, drains the buffer through a valid/ready output port, rounding and saturating each result to output feature-map format.

---
 rtl/ws_psum_accumulator.sv | 172 +++++++++++++++++
 tb/tb_ws_psum_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws_psum_accumulator.sv
// Multi-pass partial-sum accumulator behind a weight-stationary PE column.
// Beats accumulate per output position; after the last pass, results drain rounded and saturated.
module ws_psum_accumulator #(
  parameter int PSUM_WIDTH     = 24,
  parameter int PSUM_INT_WIDTH = 10,
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_INT_WIDTH  = 8,
  parameter int DEPTH          = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_pass,
  input  logic [CNT_WIDTH-1:0]  num_pix,
  input  logic                  psum_i_valid,
  input  logic [PSUM_WIDTH-1:0] psum_i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_drop
);

  localparam int PSUM_FRAC = PSUM_WIDTH - PSUM_INT_WIDTH;
  localparam int OUT_FRAC  = OUT_WIDTH - OUT_INT_WIDTH;
  localparam int SHIFT     = PSUM_FRAC - OUT_FRAC;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0]        ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]        DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]   RND     = (ACC_WIDTH+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_WIDTH:0]   OMAX    = (ACC_WIDTH+1)'((2**(OUT_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH:0]   OMIN    = -OMAX - (ACC_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t r_state, w_next;

  logic [CNT_WIDTH-1:0] r_num_pass, r_num_pix;
  logic [CNT_WIDTH-1:0] r_pass_cnt, r_pix_ptr, r_rd_ptr;
  logic signed [ACC_WIDTH-1:0] r_buf [DEPTH];

  logic                        w_beat, w_pix_last, w_pass_last, w_final_hs, w_load;
  logic signed [ACC_WIDTH-1:0] w_ext, w_old, w_sat, w_rd;
  logic signed [ACC_WIDTH:0]   w_sum, w_rnd, w_shr;
  logic [OUT_WIDTH-1:0]        w_conv;

  assign w_beat      = (r_state == S_ACCUM) && psum_i_valid;
  assign w_pix_last  = (r_pix_ptr == r_num_pix - ONE);
  assign w_pass_last = (r_pass_cnt == r_num_pass - ONE);
  // r_rd_ptr == r_num_pix means every entry has been issued; only the final beat may remain in flight.
  assign w_final_hs  = (r_state == S_DRAIN) && o_valid && o_ready && (r_rd_ptr == r_num_pix);
  assign w_load      = (r_state == S_DRAIN) && (!o_valid || o_ready) && (r_rd_ptr != r_num_pix);
  assign busy        = (r_state != S_IDLE);

  assign w_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum_i_data[PSUM_WIDTH-1]}}, psum_i_data};
  assign w_old = r_buf[r_pix_ptr[AW-1:0]];
  assign w_sum = {w_old[ACC_WIDTH-1], w_old} + {w_ext[ACC_WIDTH-1], w_ext};

  always_comb begin
    w_sat = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_sat = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  assign w_rd  = r_buf[r_rd_ptr[AW-1:0]];
  assign w_rnd = {w_rd[ACC_WIDTH-1], w_rd} + RND;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    w_conv = w_shr[OUT_WIDTH-1:0];
    if (w_shr > OMAX) begin
      w_conv = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (w_shr < OMIN) begin
      w_conv = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACCUM;
      S_ACCUM: if (psum_i_valid && w_pix_last && w_pass_last) w_next = S_DRAIN;
      S_DRAIN: if (w_final_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clr) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_pass <= '0;
      r_num_pix  <= '0;
      r_pass_cnt <= '0;
      r_pix_ptr  <= '0;
      r_rd_ptr   <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      done       <= 1'b0;
      err_drop   <= 1'b0;
    end else if (clr) begin
      r_pass_cnt <= '0;
      r_pix_ptr  <= '0;
      r_rd_ptr   <= '0;
      o_valid    <= 1'b0;
      done       <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (psum_i_valid && r_state != S_ACCUM) begin
        err_drop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pass <= (num_pass == '0) ? ONE : num_pass;
            r_num_pix  <= (num_pix == '0) ? ONE : ((num_pix > DEPTH_C) ? DEPTH_C : num_pix);
            r_pass_cnt <= '0;
            r_pix_ptr  <= '0;
            r_rd_ptr   <= '0;
          end
        end
        S_ACCUM: begin
          if (psum_i_valid) begin
            if (w_pix_last) begin
              r_pix_ptr  <= '0;
              r_pass_cnt <= r_pass_cnt + ONE;
            end else begin
              r_pix_ptr <= r_pix_ptr + ONE;
            end
          end
        end
        S_DRAIN: begin
          if (w_final_hs) begin
            o_valid <= 1'b0;
            done    <= 1'b1;
          end else if (w_load) begin
            o_data   <= w_conv;
            o_valid  <= 1'b1;
            r_rd_ptr <= r_rd_ptr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // First pass overwrites, so stale contents from an aborted job never leak into results.
  always_ff @(posedge clk) begin
    if (!clr && w_beat) begin
      r_buf[r_pix_ptr[AW-1:0]] <= (r_pass_cnt == '0) ? w_ext : w_sat;
    end
  end

endmodule

// File: tb/tb_ws_psum_accumulator.sv
// Self-checking bench for ws_psum_accumulator: directed and random jobs
// compared against a plain-arithmetic reference model.
module tb_ws_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, clr, start, psum_i_valid, o_ready;
  logic [7:0]  num_pass, num_pix;
  logic [23:0] psum_i_data;
  logic        o_valid, busy, done, err_drop;
  logic [15:0] o_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] beats[$];
  logic [15:0] fixed_exp[$];
  logic        exp_err = 1'b0;

  ws_psum_accumulator #(
    .PSUM_WIDTH(24), .PSUM_INT_WIDTH(10), .ACC_WIDTH(32),
    .OUT_WIDTH(16), .OUT_INT_WIDTH(8), .DEPTH(16), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .num_pass(num_pass), .num_pix(num_pix),
    .psum_i_valid(psum_i_valid), .psum_i_data(psum_i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .busy(busy), .done(done), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Q10.14 accumulator -> Q8.8: round half up, floor shift, clamp to 16-bit signed.
  function automatic logic [15:0] ref_conv(input longint a);
    longint r;
    r = (a + 32) >>> 6;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic longint sat32(input longint a);
    if (a > 64'sd2147483647)  return 64'sd2147483647;
    if (a < -64'sd2147483648) return -64'sd2147483648;
    return a;
  endfunction

  function automatic int eff_pass(input int np);
    return (np == 0) ? 1 : np;
  endfunction

  function automatic int eff_pix(input int nx);
    return (nx == 0) ? 1 : ((nx > 16) ? 16 : nx);
  endfunction

  task automatic fill_random(input int n);
    logic [23:0] d;
    for (int i = 0; i < n; i++) begin
      d = 24'($urandom);
      if ($urandom_range(0, 2) == 0) d = {{8{d[15]}}, d[15:0]};
      beats.push_back(d);
    end
  endtask

  // rmode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random ready
  task automatic run_job(input string tag, input int np, input int nx, input int rmode, input bit bubbles);
    int ep, ex, k, cyc;
    longint acc[16];
    longint v;
    logic [15:0] expv[16];
    logic [15:0] held;
    bit stalled;
    logic [23:0] d;
    ep = eff_pass(np);
    ex = eff_pix(nx);
    @(negedge clk);
    start = 1'b1; num_pass = 8'(np); num_pix = 8'(nx); o_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int p = 0; p < ep; p++) begin
      for (int x = 0; x < ex; x++) begin
        if (bubbles && $urandom_range(0, 3) == 0) begin
          psum_i_valid = 1'b0;
          @(negedge clk);
        end
        d = beats.pop_front();
        v = $signed(d);
        acc[x] = (p == 0) ? v : sat32(acc[x] + v);
        psum_i_valid = 1'b1;
        psum_i_data  = d;
        @(negedge clk);
      end
    end
    psum_i_valid = 1'b0;
    for (int x = 0; x < ex; x++) expv[x] = ref_conv(acc[x]);
    k = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (k < ex && cyc < 1000) begin
      if (rmode == 0)      o_ready = 1'b1;
      else if (rmode == 1) o_ready = (cyc % 3 == 0);
      else                 o_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        check({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_hold_data"}, {16'd0, o_data}, {16'd0, held});
      end
      stalled = 1'b0;
      if (o_valid) begin
        if (o_ready) begin
          check({tag, "_data"}, {16'd0, o_data}, {16'd0, expv[k]});
          if (fixed_exp.size() > 0) check({tag, "_spec"}, {16'd0, o_data}, {16'd0, fixed_exp.pop_front()});
          k++;
        end else begin
          stalled = 1'b1;
          held    = o_data;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check({tag, "_drain_count"}, 32'(k), 32'(ex));
    o_ready = 1'b0;
    check({tag, "_done"}, {29'd0, done, busy, o_valid}, 32'b100);
    @(negedge clk);
    check({tag, "_done_end"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err_drop}, {31'd0, exp_err});
    fixed_exp.delete();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; psum_i_valid = 1'b0; o_ready = 1'b0;
    num_pass = '0; num_pix = '0; psum_i_data = '0;
    #12;
    check("reset_outputs", {11'd0, o_valid, o_data, busy, done, err_drop}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 3 passes x 2 pixels of 1.0 -> 3.0 each
    repeat (6) beats.push_back(24'h004000);
    fixed_exp.push_back(16'h0300); fixed_exp.push_back(16'h0300);
    run_job("three_pass", 3, 2, 0, 1'b0);

    beats.push_back(24'h000020); fixed_exp.push_back(16'h0001);
    run_job("round_half", 1, 1, 0, 1'b0);
    beats.push_back(24'hFFFFE0); fixed_exp.push_back(16'h0000);
    run_job("round_neg_half", 1, 1, 0, 1'b0);
    repeat (2) beats.push_back(24'h7FFFFF); fixed_exp.push_back(16'h7FFF);
    run_job("sat_pos", 2, 1, 0, 1'b0);
    repeat (2) beats.push_back(24'h800000); fixed_exp.push_back(16'h8000);
    run_job("sat_neg", 2, 1, 0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      beats.push_back(24'(i * 24'h004000));
      fixed_exp.push_back(16'(i * 16'h0100));
    end
    run_job("stall", 1, 4, 1, 1'b0);

    // stray beat in IDLE
    @(negedge clk); psum_i_valid = 1'b1; psum_i_data = 24'h123456;
    @(negedge clk); psum_i_valid = 1'b0;
    exp_err = 1'b1;
    check("idle_drop_err", {31'd0, err_drop}, 32'd1);
    check("idle_drop_busy", {31'd0, busy}, 32'd0);
    fill_random(3);
    run_job("sticky_err", 1, 3, 2, 1'b1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_err = 1'b0;
    check("clr_err", {31'd0, err_drop}, 32'd0);

    // abort mid-accumulation with a simultaneous beat
    @(negedge clk); start = 1'b1; num_pass = 8'd3; num_pix = 8'd2;
    @(negedge clk); start = 1'b0;
    repeat (2) begin
      psum_i_valid = 1'b1; psum_i_data = 24'h3FFFFF;
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; psum_i_valid = 1'b0;
    check("clr_abort", {29'd0, busy, o_valid, err_drop}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("clr_no_valid", {30'd0, o_valid, busy}, 32'd0);
    end
    fill_random(6);
    run_job("after_clr", 3, 2, 0, 1'b0);

    // async reset while an output is stalled
    fill_random(2);
    @(negedge clk); start = 1'b1; num_pass = 8'd1; num_pix = 8'd2; o_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (2) begin
      psum_i_valid = 1'b1; psum_i_data = beats.pop_front();
      @(negedge clk);
    end
    psum_i_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_valid", {31'd0, o_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {11'd0, o_valid, o_data, busy, done, err_drop}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // clamp and zero-config cases, then random jobs
    fill_random(16);
    run_job("pix_clamp", 1, 20, 2, 1'b0);
    fill_random(1);
    run_job("zero_cfg", 0, 0, 0, 1'b0);
    for (int j = 0; j < 12; j++) begin
      int np, nx;
      np = $urandom_range(0, 5);
      nx = $urandom_range(0, 18);
      fill_random(eff_pass(np) * eff_pix(nx));
      run_job("rand", np, nx, 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
